// File: rtl/bpu_correct_gen_if.sv
// bpu_correct_gen_if: shared BPU correction types plus the commit/correction bundle interface

package bpu_correct_gen_pkg;
    localparam int HIST_LEN = 5;

    typedef enum logic [1:0] {BR_NORMAL, BR_CALL, BR_RET, BR_INDIRECT} br_type_e;

    // Prediction captured at fetch and carried down the pipe with the instruction
    typedef struct packed {
        logic                is_branch;
        br_type_e            br_type;
        logic [31:0]         next_pc;
        logic [31:0]         target_pc;
        logic [HIST_LEN-1:0] history;
        logic [1:0]          scnt;
    } predict_info_t;

    // One update request to the BPU; all-zero means "no update, no RAS action"
    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         target_pc;
        logic                update;
        logic                type_miss;
        logic                target_miss;
        logic                taken;
        br_type_e            branch_type;
        logic                is_branch;
        logic [HIST_LEN-1:0] history;
        logic [1:0]          scnt;
    } correct_info_t;
endpackage

interface bpu_correct_gen_if #(parameter int QDEPTH = 8);
    logic                                     [1:0] cmt_valid_i;
    logic [1:0][31:0]                               cmt_pc_i;
    bpu_correct_gen_pkg::predict_info_t       [1:0] cmt_pred_i;
    logic                                     [1:0] cmt_is_branch_i;
    bpu_correct_gen_pkg::br_type_e            [1:0] cmt_br_type_i;
    logic                                     [1:0] cmt_taken_i;
    logic [1:0][31:0]                               cmt_target_i;
    logic                                           cmt_ready_o;
    bpu_correct_gen_pkg::correct_info_t       [1:0] correct_infos_o;
    logic                                           flush_o;
    logic [31:0]                                    redir_addr_o;
    logic [$clog2(QDEPTH):0]                        q_count_o;

    // Commit side drives the retire bundle and observes the correction outputs
    modport master (
        output cmt_valid_i, cmt_pc_i, cmt_pred_i, cmt_is_branch_i, cmt_br_type_i,
               cmt_taken_i, cmt_target_i,
        input  cmt_ready_o, correct_infos_o, flush_o, redir_addr_o, q_count_o
    );

    // Correction generator consumes the retire bundle
    modport slave (
        input  cmt_valid_i, cmt_pc_i, cmt_pred_i, cmt_is_branch_i, cmt_br_type_i,
               cmt_taken_i, cmt_target_i,
        output cmt_ready_o, correct_infos_o, flush_o, redir_addr_o, q_count_o
    );
endinterface

// File: rtl/bpu_correct_gen.sv
// bpu_correct_gen: classifies committed instructions, queues BPU updates and raises redirects
module bpu_correct_gen
    import bpu_correct_gen_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    bpu_correct_gen_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);

    correct_info_t mem_q [QDEPTH];
    correct_info_t mem_d [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          flush_q, flush_d;
    logic [31:0]   redir_q, redir_d;
    logic          ready, pop;
    logic [1:0]    mis, en, push;
    logic [31:0]   act_next [2];
    correct_info_t ent [2];

    // Ready leaves room for a double push regardless of this cycle's pop
    assign ready = rst_n & (count_q <= (AW+1)'(QDEPTH - 2));
    assign pop   = count_q != '0;

    // Per-slot resolution: actual next pc, mispredict flag and the candidate queue entry
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            act_next[i] = bus.cmt_taken_i[i] ? bus.cmt_target_i[i] : bus.cmt_pc_i[i] + 32'd4;
            mis[i]      = bus.cmt_pred_i[i].next_pc != act_next[i];
            ent[i]      = '{
                pc:          bus.cmt_pc_i[i],
                target_pc:   bus.cmt_target_i[i],
                update:      1'b1,
                type_miss:   (bus.cmt_pred_i[i].is_branch != bus.cmt_is_branch_i[i]) |
                             (bus.cmt_is_branch_i[i] & (bus.cmt_pred_i[i].br_type != bus.cmt_br_type_i[i])),
                target_miss: bus.cmt_is_branch_i[i] & bus.cmt_taken_i[i] &
                             (bus.cmt_pred_i[i].target_pc != bus.cmt_target_i[i]),
                taken:       bus.cmt_taken_i[i],
                branch_type: bus.cmt_br_type_i[i],
                is_branch:   bus.cmt_is_branch_i[i],
                history:     bus.cmt_pred_i[i].history,
                scnt:        bus.cmt_pred_i[i].scnt
            };
        end
    end

    // A mispredicted slot 0 kills the younger slot 1 entirely
    assign en = {bus.cmt_valid_i[1] & ~(bus.cmt_valid_i[0] & mis[0]), bus.cmt_valid_i[0]} & {2{ready}};
    assign push = en & {bus.cmt_is_branch_i[1] | bus.cmt_pred_i[1].is_branch,
                        bus.cmt_is_branch_i[0] | bus.cmt_pred_i[0].is_branch};

    // Queue write/pointer/count bookkeeping and redirect selection of the oldest mispredict
    always_comb begin
        mem_d = mem_q;
        if (push[0]) mem_d[wr_ptr_q] = ent[0];
        if (push[1]) mem_d[wr_ptr_q + AW'(push[0])] = ent[1];
        wr_ptr_d = wr_ptr_q + AW'(push[0]) + AW'(push[1]);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push[0]) + (AW+1)'(push[1]) - (AW+1)'(pop);
        flush_d  = |(en & mis);
        redir_d  = (en[0] & mis[0]) ? act_next[0] : (en[1] & mis[1]) ? act_next[1] : redir_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flush_q  <= 1'b0;
            redir_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flush_q  <= flush_d;
            redir_q  <= redir_d;
        end
    end

    assign bus.cmt_ready_o        = ready;
    assign bus.correct_infos_o[0] = pop ? mem_q[rd_ptr_q] : '0;
    assign bus.correct_infos_o[1] = '0;
    assign bus.flush_o            = flush_q;
    assign bus.redir_addr_o       = redir_q;
    assign bus.q_count_o          = count_q;
endmodule

// File: tb/tb_bpu_correct_gen.sv
// tb_bpu_correct_gen: directed plus randomized checks of bpu_correct_gen against a queue model
module tb_bpu_correct_gen;
    import bpu_correct_gen_pkg::*;

    localparam int QDEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    correct_info_t mq[$];
    logic          exp_flush = 1'b0;
    logic [31:0]   exp_redir = '0;

    bpu_correct_gen_if #(.QDEPTH(QDEPTH)) bus ();

    bpu_correct_gen #(.QDEPTH(QDEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: apply the commit rules to a plain queue on each rising edge
    task automatic model_update();
        logic accept, killed, m;
        logic [31:0] an;
        correct_info_t e;
        if (!rst_n) begin
            mq.delete();
            exp_flush = 1'b0;
            exp_redir = '0;
            return;
        end
        accept = mq.size() <= QDEPTH - 2;
        if (mq.size() > 0) void'(mq.pop_front());
        exp_flush = 1'b0;
        killed = 1'b0;
        if (accept) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.cmt_valid_i[i] && !killed) begin
                    an = bus.cmt_taken_i[i] ? bus.cmt_target_i[i] : bus.cmt_pc_i[i] + 32'd4;
                    m = bus.cmt_pred_i[i].next_pc != an;
                    if (bus.cmt_is_branch_i[i] || bus.cmt_pred_i[i].is_branch) begin
                        e.pc          = bus.cmt_pc_i[i];
                        e.target_pc   = bus.cmt_target_i[i];
                        e.update      = 1'b1;
                        e.type_miss   = (bus.cmt_pred_i[i].is_branch != bus.cmt_is_branch_i[i]) ||
                                        (bus.cmt_is_branch_i[i] && bus.cmt_pred_i[i].br_type != bus.cmt_br_type_i[i]);
                        e.target_miss = bus.cmt_is_branch_i[i] && bus.cmt_taken_i[i] &&
                                        bus.cmt_pred_i[i].target_pc != bus.cmt_target_i[i];
                        e.taken       = bus.cmt_taken_i[i];
                        e.branch_type = bus.cmt_br_type_i[i];
                        e.is_branch   = bus.cmt_is_branch_i[i];
                        e.history     = bus.cmt_pred_i[i].history;
                        e.scnt        = bus.cmt_pred_i[i].scnt;
                        mq.push_back(e);
                    end
                    if (m) begin
                        exp_flush = 1'b1;
                        exp_redir = an;
                        killed = 1'b1;
                    end
                end
            end
        end
    endtask

    // Compare every output against the model half a cycle after each edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", bus.cmt_ready_o, rst_n && mq.size() <= QDEPTH - 2);
            chk("count", bus.q_count_o, mq.size());
            chk("out0", bus.correct_infos_o[0], mq.size() > 0 ? mq[0] : '0);
            chk("out1", bus.correct_infos_o[1], '0);
            chk("flush", bus.flush_o, exp_flush);
            chk("redir", bus.redir_addr_o, exp_redir);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic set_slot(input int i, input logic v, input logic [31:0] pc, input logic isb,
                            input br_type_e bt, input logic tk, input logic [31:0] tgt,
                            input predict_info_t p);
        bus.cmt_valid_i[i]     = v;
        bus.cmt_pc_i[i]        = pc;
        bus.cmt_is_branch_i[i] = isb;
        bus.cmt_br_type_i[i]   = bt;
        bus.cmt_taken_i[i]     = tk;
        bus.cmt_target_i[i]    = tgt;
        bus.cmt_pred_i[i]      = p;
    endtask

    task automatic idle();
        bus.cmt_valid_i = 2'b00;
    endtask

    task automatic rand_slot(input int i);
        logic [31:0] pc, tgt, an;
        logic isb, tk;
        br_type_e bt;
        predict_info_t p;
        pc  = 32'h1c000000 + ($urandom_range(0, 255) << 2);
        isb = $urandom_range(0, 3) != 0;
        bt  = br_type_e'($urandom_range(0, 3));
        tk  = isb && $urandom_range(0, 1) == 1;
        tgt = 32'h1c000000 + ($urandom_range(0, 255) << 2);
        an  = tk ? tgt : pc + 32'd4;
        p.is_branch = $urandom_range(0, 3) != 0 ? isb : ~isb;
        p.br_type   = $urandom_range(0, 3) != 0 ? bt : br_type_e'($urandom_range(0, 3));
        p.next_pc   = $urandom_range(0, 3) != 0 ? an : 32'h1c000000 + ($urandom_range(0, 255) << 2);
        p.target_pc = $urandom_range(0, 3) != 0 ? tgt : 32'h1c000000 + ($urandom_range(0, 255) << 2);
        p.history   = 5'($urandom);
        p.scnt      = 2'($urandom);
        set_slot(i, 1'($urandom_range(0, 1)), pc, isb, bt, tk, tgt, p);
    endtask

    initial begin
        predict_info_t p0, p1;
        int acc, cyc;
        bit saw_stall;
        p0 = '0;
        set_slot(0, 1'b0, '0, 1'b0, BR_NORMAL, 1'b0, '0, p0);
        set_slot(1, 1'b0, '0, 1'b0, BR_NORMAL, 1'b0, '0, p0);

        // 1: reset state
        step();
        chk_en = 1'b1;
        repeat (2) step();
        chk("t1_out0", bus.correct_infos_o[0], '0);
        chk("t1_flush", bus.flush_o, 1'b0);
        chk("t1_count", bus.q_count_o, 0);
        chk("t1_ready_in_reset", bus.cmt_ready_o, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("t1_ready_after", bus.cmt_ready_o, 1'b1);

        // 2: BEQ taken but predicted as a non-branch
        p0 = '{is_branch: 1'b0, br_type: BR_NORMAL, next_pc: 32'h1c000014, target_pc: '0, history: 5'h15, scnt: 2'd2};
        set_slot(0, 1'b1, 32'h1c000010, 1'b1, BR_NORMAL, 1'b1, 32'h1c000100, p0);
        step();
        idle();
        chk("t2_update", bus.correct_infos_o[0].update, 1'b1);
        chk("t2_type_miss", bus.correct_infos_o[0].type_miss, 1'b1);
        chk("t2_taken", bus.correct_infos_o[0].taken, 1'b1);
        chk("t2_target", bus.correct_infos_o[0].target_pc, 32'h1c000100);
        chk("t2_history", bus.correct_infos_o[0].history, 5'h15);
        chk("t2_flush", bus.flush_o, 1'b1);
        chk("t2_redir", bus.redir_addr_o, 32'h1c000100);
        repeat (3) step();
        chk("t2_redir_hold", bus.redir_addr_o, 32'h1c000100);

        // 3: slot 0 mispredict kills a younger CALL
        p0 = '{is_branch: 1'b1, br_type: BR_NORMAL, next_pc: 32'h104, target_pc: 32'h200, history: 5'h3, scnt: 2'd1};
        p1 = '{is_branch: 1'b1, br_type: BR_CALL, next_pc: 32'h900, target_pc: 32'h900, history: 5'h4, scnt: 2'd3};
        set_slot(0, 1'b1, 32'h100, 1'b1, BR_NORMAL, 1'b1, 32'h200, p0);
        set_slot(1, 1'b1, 32'h104, 1'b1, BR_CALL, 1'b1, 32'h900, p1);
        step();
        idle();
        chk("t3_count", bus.q_count_o, 1);
        chk("t3_pc", bus.correct_infos_o[0].pc, 32'h100);
        chk("t3_btype", bus.correct_infos_o[0].branch_type, BR_NORMAL);
        chk("t3_flush", bus.flush_o, 1'b1);
        chk("t3_redir", bus.redir_addr_o, 32'h200);
        step();
        chk("t3_drained", bus.q_count_o, 0);

        // 4: slot 1 only, correctly predicted taken branch
        p1 = '{is_branch: 1'b1, br_type: BR_NORMAL, next_pc: 32'h400, target_pc: 32'h400, history: 5'h9, scnt: 2'd3};
        set_slot(1, 1'b1, 32'h300, 1'b1, BR_NORMAL, 1'b1, 32'h400, p1);
        step();
        idle();
        chk("t4_flush", bus.flush_o, 1'b0);
        chk("t4_update", bus.correct_infos_o[0].update, 1'b1);
        chk("t4_misses", {bus.correct_infos_o[0].type_miss, bus.correct_infos_o[0].target_miss}, 2'b00);
        chk("t4_count", bus.q_count_o, 1);
        step();

        // 5: plain non-branches on both slots
        p0 = '{is_branch: 1'b0, br_type: BR_NORMAL, next_pc: 32'h504, target_pc: '0, history: '0, scnt: '0};
        p1 = '{is_branch: 1'b0, br_type: BR_NORMAL, next_pc: 32'h508, target_pc: '0, history: '0, scnt: '0};
        set_slot(0, 1'b1, 32'h500, 1'b0, BR_NORMAL, 1'b0, '0, p0);
        set_slot(1, 1'b1, 32'h504, 1'b0, BR_NORMAL, 1'b0, '0, p1);
        step();
        idle();
        chk("t5_count", bus.q_count_o, 0);
        chk("t5_out0", bus.correct_infos_o[0], '0);
        chk("t5_flush", bus.flush_o, 1'b0);

        // 6: sustained double commits, holding while not ready
        acc = 0;
        cyc = 0;
        saw_stall = 1'b0;
        while (acc < 8 && cyc < 40) begin
            p0 = '{is_branch: 1'b1, br_type: BR_NORMAL, next_pc: 32'h3000 + acc * 16, target_pc: 32'h3000 + acc * 16, history: 5'(acc), scnt: 2'd1};
            p1 = '{is_branch: 1'b1, br_type: BR_RET, next_pc: 32'h4000 + acc * 16, target_pc: 32'h4000 + acc * 16, history: 5'(acc + 16), scnt: 2'd2};
            set_slot(0, 1'b1, 32'h2000 + acc * 16, 1'b1, BR_NORMAL, 1'b1, 32'h3000 + acc * 16, p0);
            set_slot(1, 1'b1, 32'h2004 + acc * 16, 1'b1, BR_RET, 1'b1, 32'h4000 + acc * 16, p1);
            if (mq.size() == 7) begin
                chk("t6_stall_at7", bus.cmt_ready_o, 1'b0);
                saw_stall = 1'b1;
            end
            if (bus.cmt_ready_o) acc++;
            cyc++;
            step();
        end
        idle();
        chk("t6_accepted", acc, 8);
        chk("t6_saw_stall", saw_stall, 1'b1);
        repeat (10) step();
        chk("t6_empty", bus.q_count_o, 0);

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 600; n++) begin
            rst_n = $urandom_range(0, 59) != 0;
            rand_slot(0);
            rand_slot(1);
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (10) step();
        chk("final_empty", bus.q_count_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
